// File: rtl/vblank_access_arbiter.sv
// vblank_access_arbiter
//   Arbitrates a frame-critical write port among NUM_REQ requesters. Grants are
//   only issued while the VGA beam is in vertical blanking, each requester is
//   served at most once per frame (round robin), and a grant still held when
//   active video resumes is revoked with an overrun pulse.
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   y_pos        current line from the VGA sync generator
//   req          per-requester request, held until done or abandoned
//   done         per-requester finish pulse (only the granted index counts)
//   grant        one-hot or zero, registered
//   busy         registered |grant
//   vblank       registered (y_pos >= V_DISPLAY)
//   frame_start  one-clk pulse on the rising edge of vblank
//   frame_count  frames since reset, wraps
//   overrun      one-clk pulse when a grant is force-revoked
module vblank_access_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned GUARD_LINES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         y_pos,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               vblank,
  output logic               frame_start,
  output logic [15:0]        frame_count,
  output logic               overrun
);

  localparam int unsigned Y_W   = 10;
  localparam int unsigned FC_W  = 16;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [Y_W-1:0]   V_DISP_Y   = Y_W'(V_DISPLAY);
  localparam logic [Y_W-1:0]   OPEN_END_Y = Y_W'(V_TOTAL - GUARD_LINES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ARB, GRANT, CLOSED} state_t;

  state_t               state, state_n;
  logic [NUM_REQ-1:0]   served, served_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic [IDX_W-1:0]     rr_ptr, rr_n;
  logic [IDX_W-1:0]     gnt_idx, gnt_idx_n;
  logic [FC_W-1:0]      fc_n;
  logic                 fs_n, ov_n;
  logic                 vblank_q;

  logic                 open_c, active_c, vb_c, release_c;
  logic                 cand_found;
  logic [IDX_W-1:0]     cand_idx;
  int unsigned          pos;
  logic [IDX_W-1:0]     pos_idx;

  // Window decode from the current line
  assign active_c = (y_pos < V_DISP_Y);
  assign vb_c     = ~active_c;
  assign open_c   = (y_pos >= V_DISP_Y) && (y_pos < OPEN_END_Y);

  // Granted requester finished or gave up
  assign release_c = done[gnt_idx] | ~req[gnt_idx];

  // Round-robin search starting at rr_ptr over unserved requesters
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    pos        = 0;
    pos_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = k + 32'(rr_ptr);
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!cand_found && req[pos_idx] && !served[pos_idx]) begin
        cand_found = 1'b1;
        cand_idx   = pos_idx;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    served_n  = served;
    rr_n      = rr_ptr;
    gnt_idx_n = gnt_idx;
    fc_n      = frame_count;
    fs_n      = 1'b0;
    ov_n      = 1'b0;
    case (state)
      IDLE: begin
        if (vb_c && !vblank_q) begin
          fs_n     = 1'b1;
          fc_n     = frame_count + FC_W'(1);
          served_n = '0;
          state_n  = ARB;
        end
      end
      ARB: begin
        if (!open_c) begin
          state_n = CLOSED;
        end else if (cand_found) begin
          grant_n   = NUM_REQ'(1) << cand_idx;
          served_n  = served | (NUM_REQ'(1) << cand_idx);
          rr_n      = (cand_idx == LAST_IDX) ? '0 : cand_idx + IDX_W'(1);
          gnt_idx_n = cand_idx;
          state_n   = GRANT;
        end
      end
      GRANT: begin
        // A release in the same clk as active video wins: no overrun
        if (release_c) begin
          grant_n = '0;
          state_n = ARB;
        end else if (active_c) begin
          grant_n = '0;
          ov_n    = 1'b1;
          state_n = IDLE;
        end
      end
      CLOSED: begin
        if (active_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; vblank_q resets high so a mid-vblank release waits a frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      served      <= '0;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      frame_count <= '0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
      vblank      <= 1'b0;
      vblank_q    <= 1'b1;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      busy        <= |grant_n;
      served      <= served_n;
      rr_ptr      <= rr_n;
      gnt_idx     <= gnt_idx_n;
      frame_count <= fc_n;
      frame_start <= fs_n;
      overrun     <= ov_n;
      vblank      <= vb_c;
      vblank_q    <= vb_c;
    end
  end

endmodule

// File: tb/tb_vblank_access_arbiter.sv
// Directed bench for vblank_access_arbiter: reset, round robin, guard lines,
// forced revoke, ignored done, abandon, frame counter wrap, reset mid-grant.
module tb_vblank_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic [9:0]  y_pos;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [3:0]  grant;
  logic        busy;
  logic        vblank;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  vblank_access_arbiter #(
    .NUM_REQ(4), .V_DISPLAY(480), .V_TOTAL(521), .GUARD_LINES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .y_pos(y_pos), .req(req), .done(done),
    .grant(grant), .busy(busy), .vblank(vblank), .frame_start(frame_start),
    .frame_count(frame_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; y_pos = 10'd100; req = 4'b0000; done = 4'b0000;

    // Reset held for 3 clks
    tick(); tick(); tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_vblank", 32'(vblank), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    chk("rst_fc", 32'(frame_count), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    y_pos = 10'd500; tick();
    chk("rst_vblank_500", 32'(vblank), 32'h0);

    // Release mid-vblank: no grant, no frame_start
    rst_n = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midvb_grant", 32'(grant), 32'h0);
      chk("midvb_fs", 32'(frame_start), 32'h0);
    end
    chk("midvb_vblank", 32'(vblank), 32'h1);
    y_pos = 10'd0; tick();
    chk("active_vblank", 32'(vblank), 32'h0);
    y_pos = 10'd479; tick();
    chk("line479_fs", 32'(frame_start), 32'h0);

    // Frame 1: all four requesters, done 10 clks after grant
    y_pos = 10'd480; tick();
    chk("f1_fs", 32'(frame_start), 32'h1);
    chk("f1_fc", 32'(frame_count), 32'h1);
    chk("f1_grant0", 32'(grant), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("f1_grant", 32'(grant), 32'(4'b0001 << i));
      chk("f1_busy", 32'(busy), 32'h1);
      chk("f1_fs_low", 32'(frame_start), 32'h0);
      repeat (9) tick();
      chk("f1_hold", 32'(grant), 32'(4'b0001 << i));
      done = 4'(4'b0001 << i); tick(); done = 4'b0000;
      chk("f1_idle", 32'(grant), 32'h0);
      chk("f1_idle_busy", 32'(busy), 32'h0);
    end
    tick(); tick();
    chk("f1_no_regrant", 32'(grant), 32'h0);
    chk("f1_fc_hold", 32'(frame_count), 32'h1);

    // Frame 2: req 0110 -> grants 1 then 2; late req[3] in guard -> nothing
    y_pos = 10'd0; req = 4'b0110; tick(); tick();
    chk("f2_pre_fs", 32'(frame_start), 32'h0);
    y_pos = 10'd480; tick();
    chk("f2_fc", 32'(frame_count), 32'h2);
    tick();
    chk("f2_grant1", 32'(grant), 32'h2);
    done = 4'b0010; tick(); done = 4'b0000;
    chk("f2_idle", 32'(grant), 32'h0);
    tick();
    chk("f2_grant2", 32'(grant), 32'h4);
    done = 4'b0100; tick(); done = 4'b0000;
    chk("f2_idle2", 32'(grant), 32'h0);
    y_pos = 10'd519; req = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f2_guard", 32'(grant), 32'h0);
    end

    // Frame 3: req[0] never done -> revoked at line 0 with overrun
    req = 4'b0001; y_pos = 10'd0; tick(); tick();
    y_pos = 10'd480; tick();
    chk("f3_fc", 32'(frame_count), 32'h3);
    tick();
    chk("f3_grant", 32'(grant), 32'h1);
    y_pos = 10'd500; tick();
    y_pos = 10'd519; tick();
    y_pos = 10'd520; tick();
    chk("f3_guard_hold", 32'(grant), 32'h1);
    chk("f3_no_ovr", 32'(overrun), 32'h0);
    y_pos = 10'd0; tick();
    chk("f3_revoke", 32'(grant), 32'h0);
    chk("f3_ovr", 32'(overrun), 32'h1);
    tick();
    chk("f3_ovr_pulse", 32'(overrun), 32'h0);

    // Frame 4: done on non-granted index ignored; abandon by dropping req
    req = 4'b0011; y_pos = 10'd480; tick();
    chk("f4_fc", 32'(frame_count), 32'h4);
    tick();
    chk("f4_grant1", 32'(grant), 32'h2);
    done = 4'b0100; tick(); done = 4'b0000;
    chk("f4_ignore_done", 32'(grant), 32'h2);
    req = 4'b0001; tick();
    chk("f4_abandon", 32'(grant), 32'h0);
    tick();
    chk("f4_next", 32'(grant), 32'h1);
    done = 4'b0001; tick(); done = 4'b0000;
    chk("f4_rel", 32'(grant), 32'h0);

    // Done and active video in the same clk: normal release
    req = 4'b0100; tick();
    chk("f4_grant2", 32'(grant), 32'h4);
    done = 4'b0100; y_pos = 10'd0; tick(); done = 4'b0000;
    chk("same_clk_grant", 32'(grant), 32'h0);
    chk("same_clk_ovr", 32'(overrun), 32'h0);
    tick(); tick();

    // Frame 5: reset while grant[2] is held
    y_pos = 10'd480; tick();
    chk("f5_fc", 32'(frame_count), 32'h5);
    tick();
    chk("f5_grant2", 32'(grant), 32'h4);
    rst_n = 1'b0; tick();
    chk("rst_mid_grant", 32'(grant), 32'h0);
    chk("rst_mid_ovr", 32'(overrun), 32'h0);
    chk("rst_mid_fc", 32'(frame_count), 32'h0);
    rst_n = 1'b1; req = 4'b0000; y_pos = 10'd0; tick();
    chk("post_rst_ovr", 32'(overrun), 32'h0);
    tick();

    // Frame counter wrap from a preloaded value
    force dut.frame_count = 16'hFFFD;
    tick();
    release dut.frame_count;
    #1;
    chk("wrap_preload", 32'(frame_count), 32'hFFFD);
    y_pos = 10'd480; tick();
    chk("wrap_fffe", 32'(frame_count), 32'hFFFE);
    y_pos = 10'd0; tick(); tick();
    y_pos = 10'd480; tick();
    chk("wrap_ffff", 32'(frame_count), 32'hFFFF);
    y_pos = 10'd0; tick(); tick();
    y_pos = 10'd480; tick();
    chk("wrap_zero", 32'(frame_count), 32'h0);
    chk("wrap_fs", 32'(frame_start), 32'h1);
    tick();
    chk("wrap_fs_pulse", 32'(frame_start), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
